buscador_binario: RTL

- Sequential initiator that drives the comparator interface from the other end: it proposes candidate values and consumes greater-than and equal verdicts.
- Locates an unknown N-bit target by binary search, one proposal per handshake.
- The responder is any block holding the target: our combinational greater-than comparator plus an equality flag, or a user/peer FSM.
- Sits in the game/control datapath; reports the found value, success flag and number of attempts.

---
 rtl/buscador_binario.sv | 116 +++++++++++
 1 files changed

// File: rtl/buscador_binario.sv
// Binary-search initiator: proposes guesses to a responder holding an unknown
// N-bit target and narrows [lo, hi] from greater-than / equal verdicts.
module buscador_binario #(
    parameter int unsigned N  = 5,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [N-1:0]  guess,
    output logic          guess_valid,
    input  logic          resp_valid,
    input  logic          resp_mayor,
    input  logic          resp_igual,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] intentos
);

    localparam int unsigned SW = N + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CALC     = 2'd1;
    localparam logic [1:0] S_PROPONER = 2'd2;
    localparam logic [1:0] S_FIN      = 2'd3;

    logic [1:0]    state, state_d;
    logic [N-1:0]  lo, lo_d, hi, hi_d;
    logic [N-1:0]  guess_d;
    logic          guess_valid_d, busy_d, done_d, found_d;
    logic [AW-1:0] intentos_d;
    logic [SW-1:0] sum;

    // Next-state, search bounds and registered-output next values
    always_comb begin
        state_d    = state;
        lo_d       = lo;
        hi_d       = hi;
        guess_d    = guess;
        found_d    = found;
        intentos_d = intentos;
        // Midpoint sum carried at N+1 bits so hi = 2^N-1 never wraps
        sum        = SW'(lo) + SW'(hi);

        case (state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    lo_d       = '0;
                    hi_d       = '1;
                    intentos_d = '0;
                    found_d    = 1'b0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                guess_d = sum[N:1];
                state_d = S_PROPONER;
            end
            S_PROPONER: begin
                if (resp_valid) begin
                    if (intentos != '1) begin
                        intentos_d = intentos + AW'(1);
                    end
                    if (resp_igual) begin
                        found_d = 1'b1;
                        state_d = S_FIN;
                    end else if (resp_mayor && (guess == hi)) begin
                        found_d = 1'b0;
                        state_d = S_FIN;
                    end else if (resp_mayor) begin
                        lo_d    = guess + N'(1);
                        state_d = S_CALC;
                    end else if (guess == lo) begin
                        found_d = 1'b0;
                        state_d = S_FIN;
                    end else begin
                        hi_d    = guess - N'(1);
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        guess_valid_d = (state_d == S_PROPONER);
        busy_d        = (state_d == S_CALC) || (state_d == S_PROPONER);
        done_d        = (state_d == S_FIN);
    end

    // State, bounds and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lo          <= '0;
            hi          <= '0;
            guess       <= '0;
            guess_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            intentos    <= '0;
        end else begin
            state       <= state_d;
            lo          <= lo_d;
            hi          <= hi_d;
            guess       <= guess_d;
            guess_valid <= guess_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            found       <= found_d;
            intentos    <= intentos_d;
        end
    end

endmodule
